gb_cpu_opcode_fetch: RTL and testbench
======================================

// Module: gb_cpu_opcode_fetch
// PURPOSE
// - Producer side of the decoder interface: fetches opcode bytes from the memory bus and
//   presents {opcode, cb_prefix} with a valid/ready handshake to the decoder/control sequencer.
// - Owns the program counter.
// - Folds the 0xCB prefix byte into cb_prefix, so the decoder never sees a bare 0xCB prefix.
// - Accepts PC redirects (jumps/calls/interrupts) and a HALT stall from the control unit.
// PARAMETERS
// - RESET_PC   16'h0000   PC value loaded on reset (boot ROM entry)
// - CB_OPCODE  8'hCB      prefix byte value
// PORTS
// - clk           in   1   core clock; all logic on rising edge
// - rst_n         in   1   synchronous reset, active-low
// - mem_rd        out  1   read request; held with mem_addr stable until mem_rvalid
// - mem_addr      out  16  read address (= pc while mem_rd)
// - mem_rdata     in   8   read data, valid only in a mem_rvalid cycle
// - mem_rvalid    in   1   read completion strobe (>=1 cycle after mem_rd rises)
// - op_valid      out  1   opcode/cb_prefix/op_pc valid for the decoder
// - op_ready      in   1   consumer accepts; transfer = op_valid & op_ready
// - opcode        out  8   instruction byte (byte after the prefix when cb_prefix=1)
// - cb_prefix     out  1   opcode was preceded by CB_OPCODE
// - op_pc         out  16  address of first byte of the instruction (the 0xCB byte if prefixed)
// - pc            out  16  next fetch address
// - pc_load       in   1   redirect strobe, highest priority
// - pc_load_addr  in   16  redirect target
// - halt          in   1   level; blocks new instruction fetches while 1
// - halt_bug      in   1   one-cycle strobe (used only with GB_CPU_HALT_BUG_EN)
// BEHAVIOUR
// - Reset (rst_n=0 at edge), all of these take effect at once:
//   - pc=RESET_PC; mem_rd=0; mem_addr=RESET_PC.
//   - op_valid=0; opcode=8'h00; cb_prefix=0; op_pc=RESET_PC.
//   - FSM=FETCH; cb_pending=0.
//   - Reset mid-fetch or mid-present abandons the transaction; a later mem_rvalid is ignored
//     until mem_rd is asserted again.
// - FSM states:
//   - FETCH: mem_rd=1, mem_addr=pc, unless halt=1 and cb_pending=0 (then mem_rd=0, state held).
//     - On mem_rvalid: pc<=pc+1, 16-bit wrap FFFF->0000.
//     - If cb_pending=0 the byte's address goes to op_pc.
//     - If the byte is CB_OPCODE and cb_pending=0: cb_pending<=1, stay in FETCH
//       (mem_rd stays high, next address).
//     - Otherwise: opcode<=byte, cb_prefix<=cb_pending, op_valid<=1, cb_pending<=0, go to PRESENT.
//   - PRESENT: mem_rd=0; outputs held stable while op_valid & !op_ready.
//     - On transfer: op_valid<=0, go to FETCH.
//     - Minimum transfer-to-next-request latency is 1 cycle.
// - Latency: op_valid rises on the edge after mem_rvalid of the (final) opcode byte.
// - Prefixed pair: CB then CB gives opcode=8'hCB, cb_prefix=1 (prefix is never chained).
// - halt does not abort an in-flight read (mem_rd already 1 with cb_pending=0 completes).
//   halt is sampled only when starting a new instruction fetch.
// - pc_load=1 at an edge:
//   - pc<=pc_load_addr; op_valid<=0; cb_pending<=0; FSM<=FETCH.
//   - mem_rd drops for exactly one cycle.
//   - Any mem_rvalid in the same cycle is discarded.
//   - Overrides a simultaneous op_ready transfer: the transfer still counts as accepted.
//   - Overrides halt_bug.
// - op_valid & op_ready in the same cycle as reset: reset wins.
// CONFIGURATION
// - GB_CPU_HALT_BUG_EN defined:
//   - A halt_bug strobe arms a flag.
//   - The next completed byte fetch does NOT increment pc; that byte is fetched twice.
//   - The flag clears after that fetch or on pc_load/reset.
//   - Applies to a CB_OPCODE byte too: it is refetched as the suffix, giving
//     opcode=CB, cb_prefix=1.
// - GB_CPU_HALT_BUG_EN undefined: halt_bug ignored; every completed fetch increments pc.
// TESTING
// - Reset, memory returns 8'h00 at 0x0000 after 1-cycle latency, op_ready=1 ->
//   op_valid with opcode=00, cb_prefix=0, op_pc=0000, pc=0001.
// - Bytes CB,37 at 0x0100 -> single op_valid with opcode=37, cb_prefix=1, op_pc=0100, pc=0102;
//   then CB,CB -> opcode=CB, cb_prefix=1.
// - op_ready=0 for 5 cycles while presenting 3E -> outputs stable, mem_rd=0;
//   op_ready=1 -> op_valid low next cycle, mem_rd=1 one cycle later.
// - pc_load to C000 in same cycle as mem_rvalid of byte at 0x0200 -> byte discarded,
//   no op_valid, next mem_addr=C000; fetch at FFFF -> pc wraps to 0000.
// - halt=1 in PRESENT, transfer -> mem_rd stays 0 until halt=0; halt=1 after a CB byte ->
//   suffix still fetched.
// - With GB_CPU_HALT_BUG_EN: halt_bug, byte 3C at 0x0150 -> two op_valids with opcode=3C,
//   op_pc=0150 both, pc=0151 after the second; without the macro -> pc=0151 after the first.

Source files
------------

// File: rtl/gb_cpu_opcode_fetch.sv
// gb_cpu_opcode_fetch
// Fetches opcode bytes from the memory bus, folds a 0xCB prefix into cb_prefix
// and hands {opcode, cb_prefix, op_pc} to the decoder over a valid/ready handshake.
// Owns the program counter. Accepts PC redirects (pc_load) and a HALT stall.
// Optional feature macro: GB_CPU_HALT_BUG_EN -- a halt_bug strobe makes the next
// completed byte fetch leave pc unchanged, so that byte is fetched twice.
module gb_cpu_opcode_fetch #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [7:0]  CB_OPCODE = 8'hCB
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        mem_rd,
    output logic [15:0] mem_addr,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_rvalid,
    output logic        op_valid,
    input  logic        op_ready,
    output logic [7:0]  opcode,
    output logic        cb_prefix,
    output logic [15:0] op_pc,
    output logic [15:0] pc,
    input  logic        pc_load,
    input  logic [15:0] pc_load_addr,
    input  logic        halt,
    input  logic        halt_bug
);

    typedef enum logic {
        ST_FETCH   = 1'b0,
        ST_PRESENT = 1'b1
    } state_t;

    state_t      state_reg, state_next;
    logic [15:0] pc_reg, pc_next;
    logic [15:0] op_pc_reg, op_pc_next;
    logic [7:0]  opcode_reg, opcode_next;
    logic        mem_rd_reg, mem_rd_next;
    logic        op_valid_reg, op_valid_next;
    logic        cb_prefix_reg, cb_prefix_next;
    logic        cb_pending_reg, cb_pending_next;

    logic        fetch_done;
    logic        is_prefix;
    logic [15:0] pc_step;

    // A byte only counts when we actually asked for it; stray strobes are ignored.
    assign fetch_done = (state_reg == ST_FETCH) && mem_rd_reg && mem_rvalid;
    // A second 0xCB after a prefix is an ordinary suffix byte, never a new prefix.
    assign is_prefix  = !cb_pending_reg && (mem_rdata == CB_OPCODE);

`ifdef GB_CPU_HALT_BUG_EN
    logic hb_armed_reg;

    // Arms on halt_bug; consumed by the next completed byte fetch, dropped on redirect.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hb_armed_reg <= 1'b0;
        end else if (pc_load) begin
            hb_armed_reg <= 1'b0;
        end else if (halt_bug) begin
            hb_armed_reg <= 1'b1;
        end else if (fetch_done) begin
            hb_armed_reg <= 1'b0;
        end
    end

    assign pc_step = hb_armed_reg ? 16'd0 : 16'd1;
`else
    logic unused_halt_bug;
    assign unused_halt_bug = halt_bug;
    assign pc_step         = 16'd1;
`endif

    // State register plus the datapath registers that travel with it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= ST_FETCH;
            pc_reg         <= RESET_PC;
            op_pc_reg      <= RESET_PC;
            opcode_reg     <= 8'h00;
            mem_rd_reg     <= 1'b0;
            op_valid_reg   <= 1'b0;
            cb_prefix_reg  <= 1'b0;
            cb_pending_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            pc_reg         <= pc_next;
            op_pc_reg      <= op_pc_next;
            opcode_reg     <= opcode_next;
            mem_rd_reg     <= mem_rd_next;
            op_valid_reg   <= op_valid_next;
            cb_prefix_reg  <= cb_prefix_next;
            cb_pending_reg <= cb_pending_next;
        end
    end

    // Next-state logic: redirect always returns to FETCH; otherwise fetch -> present -> fetch.
    always_comb begin
        state_next = state_reg;
        if (pc_load) begin
            state_next = ST_FETCH;
        end else begin
            case (state_reg)
                ST_FETCH:   if (fetch_done && !is_prefix) state_next = ST_PRESENT;
                ST_PRESENT: if (op_valid_reg && op_ready) state_next = ST_FETCH;
                default:    state_next = ST_FETCH;
            endcase
        end
    end

    // Output/datapath next values; mem_rd is registered so a redirect drops it for one cycle.
    always_comb begin
        pc_next         = pc_reg;
        op_pc_next      = op_pc_reg;
        opcode_next     = opcode_reg;
        mem_rd_next     = mem_rd_reg;
        op_valid_next   = op_valid_reg;
        cb_prefix_next  = cb_prefix_reg;
        cb_pending_next = cb_pending_reg;
        if (pc_load) begin
            pc_next         = pc_load_addr;
            op_valid_next   = 1'b0;
            cb_pending_next = 1'b0;
            mem_rd_next     = 1'b0;
        end else begin
            case (state_reg)
                ST_FETCH: begin
                    if (!mem_rd_reg) begin
                        // Halt only gates the start of a new instruction, never a suffix.
                        if (!(halt && !cb_pending_reg)) mem_rd_next = 1'b1;
                    end else if (mem_rvalid) begin
                        pc_next = pc_reg + pc_step;
                        if (!cb_pending_reg) op_pc_next = pc_reg;
                        if (is_prefix) begin
                            cb_pending_next = 1'b1;
                        end else begin
                            opcode_next     = mem_rdata;
                            cb_prefix_next  = cb_pending_reg;
                            op_valid_next   = 1'b1;
                            cb_pending_next = 1'b0;
                            mem_rd_next     = 1'b0;
                        end
                    end
                end
                ST_PRESENT: begin
                    mem_rd_next = 1'b0;
                    if (op_valid_reg && op_ready) op_valid_next = 1'b0;
                end
                default: mem_rd_next = 1'b0;
            endcase
        end
    end

    assign mem_rd    = mem_rd_reg;
    assign mem_addr  = pc_reg;
    assign pc        = pc_reg;
    assign op_valid  = op_valid_reg;
    assign opcode    = opcode_reg;
    assign cb_prefix = cb_prefix_reg;
    assign op_pc     = op_pc_reg;

endmodule

// File: tb/tb_gb_cpu_opcode_fetch.sv
// Testbench for gb_cpu_opcode_fetch: memory responder with random latency,
// instruction-stream reference model feeding a scoreboard queue, and a monitor
// that drives op_ready and checks every accepted instruction.
module tb_gb_cpu_opcode_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_rd;
    logic [15:0] mem_addr;
    logic [7:0]  mem_rdata;
    logic        mem_rvalid;
    logic        op_valid;
    logic        op_ready;
    logic [7:0]  opcode;
    logic        cb_prefix;
    logic [15:0] op_pc;
    logic [15:0] pc;
    logic        pc_load;
    logic [15:0] pc_load_addr;
    logic        halt;
    logic        halt_bug;

    always #5 clk = ~clk;

    gb_cpu_opcode_fetch dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mem_rd       (mem_rd),
        .mem_addr     (mem_addr),
        .mem_rdata    (mem_rdata),
        .mem_rvalid   (mem_rvalid),
        .op_valid     (op_valid),
        .op_ready     (op_ready),
        .opcode       (opcode),
        .cb_prefix    (cb_prefix),
        .op_pc        (op_pc),
        .pc           (pc),
        .pc_load      (pc_load),
        .pc_load_addr (pc_load_addr),
        .halt         (halt),
        .halt_bug     (halt_bug)
    );

    typedef struct {
        logic [7:0]  op;
        logic        cb;
        logic [15:0] op_pc;
        logic [15:0] pc;
    } exp_t;

    logic [7:0] mem [0:65535];
    exp_t       exp_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         lat_max = 0;
    int         ready_pct = 100;
    bit         hold_ready = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference model: walk the instruction stream from 'start' as the decoder would see it.
    task automatic push_instrs(input logic [15:0] start, input int n);
        logic [15:0] a;
        exp_t        e;
        a = start;
        for (int i = 0; i < n; i++) begin
            e.op_pc = a;
            if (mem[a] == 8'hCB) begin
                e.op = mem[16'(a + 16'd1)];
                e.cb = 1'b1;
                a    = a + 16'd2;
            end else begin
                e.op = mem[a];
                e.cb = 1'b0;
                a    = a + 16'd1;
            end
            e.pc = a;
            exp_q.push_back(e);
        end
    endtask

    // Memory responder: latches the request address, answers after 1..lat_max+1 cycles.
    initial begin
        bit          busy = 1'b0;
        int          cnt = 0;
        logic [15:0] ra = 16'h0;
        mem_rvalid = 1'b0;
        mem_rdata  = 8'h00;
        forever begin
            @(negedge clk);
            mem_rvalid = 1'b0;
            mem_rdata  = 8'($urandom);
            if (mem_rd && rst_n) begin
                if (!busy) begin
                    busy = 1'b1;
                    ra   = mem_addr;
                    cnt  = $urandom_range(0, lat_max);
                end else begin
                    check("mem_addr_stable", mem_addr, ra);
                end
                if (cnt == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = mem[ra];
                    busy       = 1'b0;
                end else begin
                    cnt--;
                end
            end else begin
                busy = 1'b0;
            end
        end
    end

    // Monitor: decides op_ready for the coming edge and scores any transfer it implies.
    initial begin
        exp_t e;
        op_ready = 1'b0;
        forever begin
            @(negedge clk);
            op_ready = rst_n && !hold_ready && (exp_q.size() > 0) &&
                       ($urandom_range(0, 99) < ready_pct);
            if (op_valid && op_ready) begin
                e = exp_q.pop_front();
                check("opcode", {24'h0, opcode}, {24'h0, e.op});
                check("cb_prefix", {31'h0, cb_prefix}, {31'h0, e.cb});
                check("op_pc", {16'h0, op_pc}, {16'h0, e.op_pc});
                check("pc", {16'h0, pc}, {16'h0, e.pc});
                $display("txn op_pc=%h opcode=%h cb_prefix=%0d pc=%h", op_pc, opcode, cb_prefix, pc);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_load(input logic [15:0] addr);
        pc_load      = 1'b1;
        pc_load_addr = addr;
        tick();
        pc_load      = 1'b0;
    endtask

    task automatic wait_drain(input int budget, input bit rand_halt);
        int k = 0;
        while (exp_q.size() > 0 && k < budget) begin
            if (rand_halt) halt = ($urandom_range(0, 99) < 15);
            tick();
            k++;
        end
        halt = 1'b0;
        check("drain_queue", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic wait_valid(input int budget);
        int k = 0;
        while (!op_valid && k < budget) begin
            tick();
            k++;
        end
        check("op_valid_wait", {31'h0, op_valid}, 32'd1);
    endtask

    task automatic wait_rvalid(input logic [15:0] addr, input int budget);
        int k = 0;
        while (!(mem_rvalid && mem_addr == addr) && k < budget) begin
            tick();
            k++;
        end
        check("rvalid_wait", {31'h0, mem_rvalid}, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] a;
        rst_n        = 1'b0;
        pc_load      = 1'b0;
        pc_load_addr = 16'h0;
        halt         = 1'b0;
        halt_bug     = 1'b0;
        for (int i = 0; i < 65536; i++)
            mem[i] = ($urandom_range(0, 3) == 0) ? 8'hCB : 8'($urandom);
        mem[16'h0000] = 8'h00;
        mem[16'h0001] = 8'h00;
        mem[16'h0100] = 8'hCB; mem[16'h0101] = 8'h37;
        mem[16'h0102] = 8'hCB; mem[16'h0103] = 8'hCB;
        mem[16'h0150] = 8'h3C; mem[16'h0151] = 8'h00;
        mem[16'h0200] = 8'h55;
        mem[16'h0300] = 8'h3E; mem[16'h0301] = 8'h00;
        mem[16'h0400] = 8'h00; mem[16'h0401] = 8'h00;
        mem[16'h0500] = 8'hCB; mem[16'h0501] = 8'h11;
        mem[16'hC000] = 8'h12;
        mem[16'hFFFF] = 8'h21;
        repeat (3) tick();

        // Reset state
        check("rst_mem_rd", {31'h0, mem_rd}, 32'd0);
        check("rst_mem_addr", {16'h0, mem_addr}, 32'h0);
        check("rst_op_valid", {31'h0, op_valid}, 32'd0);
        check("rst_opcode", {24'h0, opcode}, 32'h0);
        check("rst_cb_prefix", {31'h0, cb_prefix}, 32'd0);
        check("rst_op_pc", {16'h0, op_pc}, 32'h0);
        check("rst_pc", {16'h0, pc}, 32'h0);

        // First fetch out of reset, 1-cycle memory
        push_instrs(16'h0000, 1);
        rst_n = 1'b1;
        wait_drain(50, 1'b0);

        // Prefixed pairs: CB 37, then CB CB
        do_load(16'h0100);
        push_instrs(16'h0100, 2);
        wait_drain(50, 1'b0);

        // Back-pressure while presenting 3E
        hold_ready = 1'b1;
        do_load(16'h0300);
        push_instrs(16'h0300, 1);
        wait_valid(50);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_op_valid", {31'h0, op_valid}, 32'd1);
            check("stall_opcode", {24'h0, opcode}, 32'h3E);
            check("stall_op_pc", {16'h0, op_pc}, 32'h0300);
            check("stall_mem_rd", {31'h0, mem_rd}, 32'd0);
        end
        hold_ready = 1'b0;
        tick();
        check("accept_queue", exp_q.size(), 0);
        tick();
        check("post_xfer_op_valid", {31'h0, op_valid}, 32'd0);
        check("post_xfer_mem_rd", {31'h0, mem_rd}, 32'd0);
        tick();
        check("refetch_mem_rd", {31'h0, mem_rd}, 32'd1);
        check("refetch_mem_addr", {16'h0, mem_addr}, 32'h0301);

        // Redirect in the same cycle as a read completion discards the byte
        do_load(16'h0200);
        wait_rvalid(16'h0200, 20);
        do_load(16'hC000);
        check("redir_op_valid", {31'h0, op_valid}, 32'd0);
        check("redir_mem_rd", {31'h0, mem_rd}, 32'd0);
        check("redir_pc", {16'h0, pc}, 32'hC000);
        push_instrs(16'hC000, 1);
        tick();
        check("redir_refetch_mem_rd", {31'h0, mem_rd}, 32'd1);
        check("redir_mem_addr", {16'h0, mem_addr}, 32'hC000);
        wait_drain(50, 1'b0);

        // PC wrap at FFFF, plain and with the prefix straddling the wrap
        do_load(16'hFFFF);
        push_instrs(16'hFFFF, 1);
        wait_drain(50, 1'b0);
        mem[16'hFFFF] = 8'hCB;
        do_load(16'hFFFF);
        push_instrs(16'hFFFF, 1);
        wait_drain(50, 1'b0);

        // Halt during PRESENT blocks the next fetch until released
        hold_ready = 1'b1;
        do_load(16'h0400);
        push_instrs(16'h0400, 1);
        wait_valid(50);
        halt       = 1'b1;
        hold_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("halt_mem_rd", {31'h0, mem_rd}, 32'd0);
        end
        check("halt_accepted", exp_q.size(), 0);
        halt = 1'b0;
        tick();
        check("unhalt_mem_rd", {31'h0, mem_rd}, 32'd1);

        // Halt after a prefix byte still fetches the suffix
        do_load(16'h0500);
        wait_rvalid(16'h0500, 20);
        halt = 1'b1;
        push_instrs(16'h0500, 1);
        begin
            int k = 0;
            while (exp_q.size() > 0 && k < 50) begin
                tick();
                k++;
            end
        end
        check("halt_cb_suffix", exp_q.size(), 0);
        exp_q.delete();
        halt = 1'b0;

        // halt_bug strobe ahead of byte 3C at 0150
        do_load(16'h0150);
        halt_bug = 1'b1;
        tick();
        halt_bug = 1'b0;
`ifdef GB_CPU_HALT_BUG_EN
        begin
            exp_t e;
            e.op = 8'h3C; e.cb = 1'b0; e.op_pc = 16'h0150; e.pc = 16'h0150;
            exp_q.push_back(e);
            e.pc = 16'h0151;
            exp_q.push_back(e);
        end
`else
        push_instrs(16'h0150, 1);
`endif
        wait_drain(50, 1'b0);

        // Reset in the middle of a fetch abandons it
        lat_max = 2;
        do_load(16'h0600);
        tick();
        rst_n = 1'b0;
        tick();
        check("midrst_op_valid", {31'h0, op_valid}, 32'd0);
        check("midrst_mem_rd", {31'h0, mem_rd}, 32'd0);
        check("midrst_pc", {16'h0, pc}, 32'h0);
        rst_n = 1'b1;
        push_instrs(16'h0000, 1);
        wait_drain(50, 1'b0);

        // Randomised segments: random target, random latency, back-pressure and halt
        ready_pct = 60;
        for (int s = 0; s < 60; s++) begin
            a = ($urandom_range(0, 7) == 0) ? 16'(16'hFFFF - $urandom_range(0, 3))
                                            : 16'($urandom);
            do_load(a);
            push_instrs(a, $urandom_range(1, 5));
            wait_drain(400, 1'b1);
            repeat ($urandom_range(0, 4)) tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
